// File: rtl/sp_ram_pkg.sv
// Constants shared by the single-port RAM, its host controller and their benches.
package sp_ram_pkg;

    localparam int SP_RAM_AW  = 4;
    localparam int SP_RAM_DW  = 8;
    localparam int RD_LAT_MIN = 1;
    localparam int RD_LAT_MAX = 3;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_WRITE   = 3'd1,
        ST_READ    = 3'd2,
        ST_CAPTURE = 3'd3,
        ST_TURN    = 3'd4,
        ST_FILL    = 3'd5
    } state_e;

endpackage

// File: rtl/bidir_buf.sv
// Tristate pad driver for the shared RAM data bus; drives pad only while oe is high.
// Combinational, no latency; no backpressure.
module bidir_buf #(
    parameter int DW = 8
) (
    input  logic          oe,
    input  logic [DW-1:0] dout,
    output logic [DW-1:0] din,
    inout  wire  [DW-1:0] pad
);

    assign pad = oe ? dout : {DW{1'bz}};
    assign din = pad;

endmodule

// File: rtl/sp_ram_master.sv
// Host controller for the single-port RAM: single read/write requests plus a hardware fill.
// Write 1 cycle, read response RD_LAT+1 edges after accept, fill DEPTH cycles; req_ready only in IDLE.
module sp_ram_master
    import sp_ram_pkg::*;
#(
    parameter int AW     = SP_RAM_AW,
    parameter int DW     = SP_RAM_DW,
    parameter int RD_LAT = 1
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          req_valid,
    output logic          req_ready,
    input  logic          req_write,
    input  logic [AW-1:0] req_addr,
    input  logic [DW-1:0] req_wdata,
    input  logic          fill_start,
    input  logic [DW-1:0] fill_value,
    output logic          fill_busy,
    output logic          rsp_valid,
    output logic [DW-1:0] rsp_rdata,
    output logic          ram_we,
    output logic          ram_re,
    output logic [AW-1:0] ram_addr,
    inout  wire  [DW-1:0] ram_data
);

    localparam int DEPTH   = 1 << AW;
    localparam int LAT_EFF = (RD_LAT < RD_LAT_MIN) ? RD_LAT_MIN :
                             (RD_LAT > RD_LAT_MAX) ? RD_LAT_MAX : RD_LAT;
    localparam int LW      = $clog2(RD_LAT_MAX);
    localparam logic [LW-1:0] LAT_LOAD  = LW'(LAT_EFF - 1);
    // Counter is one bit wider than the address so the last location never aliases to 0.
    localparam logic [AW:0]   FILL_LAST = (AW+1)'(DEPTH - 1);

    state_e        state_q, state_d;
    logic [AW:0]   cnt_q, cnt_d;
    logic [LW-1:0] lat_q, lat_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [DW-1:0] wdata_q, wdata_d;
    logic [DW-1:0] rsp_rdata_q, rsp_rdata_d;
    logic [AW-1:0] ram_addr_q, ram_addr_d;
    logic          ram_we_q, ram_we_d;
    logic          ram_re_q, ram_re_d;
    logic          rsp_valid_q, rsp_valid_d;
    logic          fill_busy_q, fill_busy_d;
    logic [DW-1:0] bus_din;

    assign req_ready = (state_q == ST_IDLE) && !fill_start;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        lat_d       = lat_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        rsp_rdata_d = rsp_rdata_q;
        unique case (state_q)
            ST_IDLE: begin
                if (fill_start) begin
                    state_d = ST_FILL;
                    cnt_d   = '0;
                    wdata_d = fill_value;
                end else if (req_valid) begin
                    addr_d  = req_addr;
                    wdata_d = req_wdata;
                    lat_d   = LAT_LOAD;
                    state_d = req_write ? ST_WRITE : ST_READ;
                end
            end
            ST_WRITE: state_d = ST_IDLE;
            ST_READ: begin
                if (lat_q == '0) state_d = ST_CAPTURE;
                else             lat_d   = lat_q - 1'b1;
            end
            ST_CAPTURE: begin
                rsp_rdata_d = bus_din;
                state_d     = ST_TURN;
            end
            ST_TURN: state_d = ST_IDLE;
            ST_FILL: begin
                if (cnt_q == FILL_LAST) state_d = ST_IDLE;
                else                    cnt_d   = cnt_q + 1'b1;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Bus-side outputs are registered from the next state so they align with it.
    always_comb begin
        ram_we_d    = (state_d == ST_WRITE) || (state_d == ST_FILL);
        ram_re_d    = (state_d == ST_READ) || (state_d == ST_CAPTURE);
        rsp_valid_d = (state_d == ST_TURN);
        fill_busy_d = (state_d == ST_FILL);
        ram_addr_d  = ram_addr_q;
        unique case (state_d)
            ST_FILL:                       ram_addr_d = cnt_d[AW-1:0];
            ST_WRITE, ST_READ, ST_CAPTURE: ram_addr_d = addr_d;
            default:                       ram_addr_d = ram_addr_q;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            lat_q       <= '0;
            addr_q      <= '0;
            wdata_q     <= '0;
            rsp_rdata_q <= '0;
            ram_addr_q  <= '0;
            ram_we_q    <= 1'b0;
            ram_re_q    <= 1'b0;
            rsp_valid_q <= 1'b0;
            fill_busy_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            lat_q       <= lat_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            rsp_rdata_q <= rsp_rdata_d;
            ram_addr_q  <= ram_addr_d;
            ram_we_q    <= ram_we_d;
            ram_re_q    <= ram_re_d;
            rsp_valid_q <= rsp_valid_d;
            fill_busy_q <= fill_busy_d;
        end
    end

    bidir_buf #(.DW(DW)) u_buf (
        .oe   (ram_we_q),
        .dout (wdata_q),
        .din  (bus_din),
        .pad  (ram_data)
    );

    assign ram_we    = ram_we_q;
    assign ram_re    = ram_re_q;
    assign ram_addr  = ram_addr_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rsp_rdata_q;
    assign fill_busy = fill_busy_q;

endmodule

// File: doc/sp_ram_master.md
# sp_ram_master

Host-side controller that drives the synchronous single-port RAM (16×8 by default) over its shared `we`/`re`/`addr`/bidirectional `data` bus. It accepts single read/write requests through a valid/ready handshake and returns read data through a one-cycle response strobe. It also runs a hardware fill sequence that writes one value to every location. It is the initiator for the RAM, and it owns all bus turnaround and contention rules.

## Interface
- `AW`, default 4: RAM address width; DEPTH = 2**AW.
- `DW`, default 8: data width.
- `RD_LAT`, default 1: cycles from `ram_re` assertion until the RAM drives valid data on `ram_data`; range 1..3.

- `clk` in 1: single clock; all state changes on the rising edge.
- `reset_n` in 1: asynchronous, active-low reset.
- `req_valid` in 1: a request is presented.
- `req_ready` out 1: the controller can accept a request.
- `req_write` in 1: 1 = write, 0 = read; sampled at accept.
- `req_addr` in AW: request address; sampled at accept.
- `req_wdata` in DW: write data; sampled at accept.
- `fill_start` in 1: start a fill of all locations; sampled in IDLE only.
- `fill_value` in DW: fill data; sampled with `fill_start`.
- `fill_busy` out 1: a fill is in progress.
- `rsp_valid` out 1: one-cycle strobe; `rsp_rdata` is valid.
- `rsp_rdata` out DW: read result; holds its value until the next read completes.
- `ram_we` out 1: RAM write enable.
- `ram_re` out 1: RAM read enable.
- `ram_addr` out AW: RAM address.
- `ram_data` inout DW: shared data bus. The controller drives it only while `ram_we`=1; otherwise it is high-Z.

## Operation
- States: IDLE, WRITE, READ, CAPTURE, TURN, FILL.
- `req_ready` = (state==IDLE) && !`fill_start`. This is combinational. A request is accepted on an edge where `req_valid` && `req_ready`.
- IDLE: `ram_we`=0, `ram_re`=0, `ram_addr` holds its last value, `ram_data` is Z.
- IDLE transitions:
  - `fill_start`=1 → FILL, with the address counter set to 0. Fill has priority over a simultaneous `req_valid`; that request stays pending.
  - Accepted write → WRITE.
  - Accepted read → READ.
- WRITE, one cycle: `ram_we`=1, `ram_addr`=latched address, `ram_data`=latched wdata. → IDLE.
- READ, RD_LAT cycles (down-counter): `ram_re`=1, `ram_addr`=latched address. → CAPTURE.
- CAPTURE, one cycle: `ram_re` stays 1. `ram_data` is sampled into `rsp_rdata` at the closing edge. → TURN.
- TURN, one cycle: `ram_we`=`ram_re`=0, bus is Z, `rsp_valid`=1. → IDLE. This dead cycle guarantees the RAM releases the bus before any controller drive.
- FILL: `ram_we`=1 and `fill_busy`=1 for DEPTH consecutive cycles. `ram_addr` counts 0..DEPTH-1 and `ram_data`=`fill_value` (latched). After address DEPTH-1 is written, → IDLE. The counter is AW+1 bits so that DEPTH-1 does not wrap before termination.
- `fill_start` outside IDLE is ignored, not queued.
- Invariants:
  - `ram_we` && `ram_re` is never 1.
  - The controller never drives `ram_data` while `ram_re`=1 or during TURN.
  - `rsp_valid` is asserted only for reads.
- Reset (any state, mid-operation included) returns to IDLE immediately:
  - `ram_we`=0, `ram_re`=0, `ram_addr`=0, `ram_data`=Z.
  - `rsp_valid`=0, `rsp_rdata`=0, `fill_busy`=0.
  - The in-flight operation is dropped with no response. A partial fill leaves the already-written locations written.
  - `req_ready`=1 after release.

## Timing
- Write: accept at edge E0; WRITE occupies E0→E1; the RAM stores at E1; `req_ready` is high again after E1. Throughput is one write per 2 cycles.
- Read: accept at E0; READ occupies E0→E(RD_LAT); CAPTURE samples at E(RD_LAT+1); `rsp_valid` is high for E(RD_LAT+1)→E(RD_LAT+2).
  - Read latency, accept to `rsp_valid` rising: RD_LAT+1 edges.
  - Occupancy: RD_LAT+3 cycles.
- Fill: `fill_busy` is high for exactly DEPTH cycles, starting the cycle after the `fill_start` edge.
- All outputs are registered except `req_ready`.

## Structure
- Shared package/header `sp_ram_pkg`:
  - State encoding localparams.
  - Default AW/DW.
  - RD_LAT bounds.
- These are shared with the RAM and its benches.
- One sub-module: `bidir_buf`, the DW-wide tristate driver (`oe`, `dout`, `din`, `pad`), isolating the inout from the FSM.
- The FSM, address/fill counter and read-latency counter live in the top.

## Test plan
- Reset: hold `reset_n`=0 for 3 cycles in the middle of a READ → `ram_we`=`ram_re`=0, `ram_addr`=0, `ram_data`=Z, `rsp_valid` never pulses; `req_ready`=1 after release.
- Write 0xA5 to addr 3, then read addr 3 (RD_LAT=1) → exactly one `rsp_valid` pulse 2 edges after the read accept, with `rsp_rdata`=0xA5. Repeat with RD_LAT=3 → pulse 4 edges after accept.
- Fill 0x3C → `fill_busy` high 16 cycles, `ram_addr` 0..15, `req_ready`=0 throughout; subsequent reads of addr 0, 7 and 15 return 0x3C.
- `fill_start`=1 and write request (addr 2, 0x11) in the same IDLE cycle → fill runs first; the request is accepted on the first IDLE cycle after the fill; read of addr 2 returns 0x11.
- Back-to-back read addr 5 then write addr 5 ← 0x77 → a TURN cycle with `ram_data`=Z between them. A bus monitor flags any we&&re, or any X on `ram_data` while `ram_we`=1; read-back returns 0x77.
- Reset asserted mid-FILL (value 0xFF) while `ram_addr`=7 → fill aborts immediately. Addr 0..6 read 0xFF; addr 7..15 keep their prior contents.
